dual_port_mem: RTL and testbench

DUAL_PORT_MEM -- requirements
Module: dual_port_mem

---
 rtl/dual_port_mem.sv | 74 +++++++
 tb/tb_dual_port_mem.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dual_port_mem.sv
// Two-port synchronous RAM that fills itself with a counting pattern after reset.
// Ports return registered read data; on a same-address double write, port A wins.
module dual_port_mem #(
    parameter int DEPTH     = 256,
    parameter int WIDTH     = 16,
    parameter int INIT_BASE = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             weA,
    input  logic [AW-1:0]    addressA,
    input  logic [WIDTH-1:0] dataInA,
    output logic [WIDTH-1:0] dataOutA,
    input  logic             weB,
    input  logic [AW-1:0]    addressB,
    input  logic [WIDTH-1:0] dataInB,
    output logic [WIDTH-1:0] dataOutB,
    output logic             ready
);

    typedef enum logic {INIT, RUN} state_t;

    state_t           state;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] init_word;
    logic             same_addr;
    logic             a_wins;

    assign init_word = WIDTH'(cnt) + WIDTH'(INIT_BASE);
    assign same_addr = (addressA == addressB);
    assign a_wins    = weA && weB && same_addr;

    // Storage has no reset: only the INIT sweep rewrites it.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[cnt] <= init_word;
        end else begin
            if (weB && !a_wins) mem[addressB] <= dataInB;
            if (weA)            mem[addressA] <= dataInA;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT;
            cnt      <= '0;
            ready    <= 1'b0;
            dataOutA <= '0;
            dataOutB <= '0;
        end else begin
            case (state)
                INIT: begin
                    dataOutA <= '0;
                    dataOutB <= '0;
                    cnt      <= cnt + 1'b1;
                    if (cnt == AW'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    ready    <= 1'b1;
                    // Write-through on the writing port; a reading port sees pre-write data.
                    dataOutA <= weA ? dataInA : mem[addressA];
                    dataOutB <= weB ? (a_wins ? dataInA : dataInB) : mem[addressB];
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_dual_port_mem.sv
// Scoreboard bench for dual_port_mem: a reference model predicts each cycle's
// outputs, pushes them to a queue, and they are popped and compared after the edge.
module tb_dual_port_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        weA = 1'b0, weB = 1'b0;
    logic [7:0]  addressA = '0, addressB = '0;
    logic [15:0] dataInA = '0, dataInB = '0;
    logic [15:0] dataOutA, dataOutB;
    logic        ready;

    dual_port_mem dut (
        .clk(clk), .rst(rst),
        .weA(weA), .addressA(addressA), .dataInA(dataInA), .dataOutA(dataOutA),
        .weB(weB), .addressB(addressB), .dataInB(dataInB), .dataOutB(dataOutB),
        .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] a;
        logic [15:0] b;
        logic        rdy;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model [256];
    bit          m_run;
    int          m_cnt;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, expv);
        end
    endtask

    // Predict the outcome of the upcoming edge from the current inputs, then step.
    task automatic run_cycle(input string tag);
        exp_t e;
        e.tag = tag;
        if (!m_run) begin
            model[m_cnt] = 16'(m_cnt + 1);
            m_cnt++;
            if (m_cnt == 256) m_run = 1'b1;
            e.a   = '0;
            e.b   = '0;
            e.rdy = m_run;
        end else begin
            e.a = weA ? dataInA : model[addressA];
            if (weB) e.b = (weA && addressA == addressB) ? dataInA : dataInB;
            else     e.b = model[addressB];
            if (weB) model[addressB] = dataInB;
            if (weA) model[addressA] = dataInA;
            e.rdy = 1'b1;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({e.tag, ".ready"}, 32'(ready), 32'(e.rdy));
        chk({e.tag, ".dataOutA"}, 32'(dataOutA), 32'(e.a));
        chk({e.tag, ".dataOutB"}, 32'(dataOutB), 32'(e.b));
    endtask

    task automatic drive(input logic wa, input logic [7:0] aa, input logic [15:0] da,
                         input logic wb, input logic [7:0] ab, input logic [15:0] db);
        weA = wa; addressA = aa; dataInA = da;
        weB = wb; addressB = ab; dataInB = db;
    endtask

    // One-cycle reset pulse applied between edges; outputs must clear at once.
    task automatic pulse_reset(input string tag);
        rst = 1'b0;
        #1;
        chk({tag, ".rst_ready"}, 32'(ready), 32'h0);
        chk({tag, ".rst_outA"}, 32'(dataOutA), 32'h0);
        chk({tag, ".rst_outB"}, 32'(dataOutB), 32'h0);
        m_run = 1'b0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        m_run = 1'b0;
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("por.ready", 32'(ready), 32'h0);
        chk("por.outA", 32'(dataOutA), 32'h0);
        chk("por.outB", 32'(dataOutB), 32'h0);
        rst = 1'b1;

        // Garbage writes during INIT must be ignored.
        drive(1'b1, 8'd10, 16'hFFFF, 1'b1, 8'd10, 16'hEEEE);
        for (int i = 0; i < 100; i++) run_cycle("init_junk");
        pulse_reset("mid_init");
        for (int i = 0; i < 256; i++) run_cycle("init_rerun");

        drive(1'b0, 8'd10, 16'h0, 1'b0, 8'd0, 16'h0);
        run_cycle("rd10");
        chk("ignored_init_write", 32'(dataOutA), 32'h000B);

        drive(1'b0, 8'd0, 16'h0, 1'b0, 8'd1, 16'h0);
        run_cycle("rd0_1");
        chk("pattern0", 32'(dataOutA), 32'h0001);
        chk("pattern1", 32'(dataOutB), 32'h0002);

        drive(1'b0, 8'd255, 16'h0, 1'b0, 8'd255, 16'h0);
        run_cycle("rd255");
        chk("pattern255", 32'(dataOutA), 32'h0100);
        chk("same_addr_read", 32'(dataOutB), 32'h0100);

        drive(1'b1, 8'd0, 16'd4, 1'b0, 8'd1, 16'h0);
        run_cycle("wrA0");
        chk("write_through", 32'(dataOutA), 32'h0004);
        drive(1'b0, 8'd3, 16'h0, 1'b0, 8'd0, 16'h0);
        run_cycle("rdB0");
        chk("cross_read", 32'(dataOutB), 32'h0004);

        drive(1'b1, 8'd2, 16'h1234, 1'b0, 8'd2, 16'h0);
        run_cycle("wr_rd_coll");
        chk("read_old_data", 32'(dataOutB), 32'h0003);

        drive(1'b1, 8'd2, 16'hAAAA, 1'b1, 8'd2, 16'h5555);
        run_cycle("ww_coll");
        chk("ww_outB", 32'(dataOutB), 32'hAAAA);
        drive(1'b0, 8'd2, 16'h0, 1'b0, 8'd2, 16'h0);
        run_cycle("ww_read");
        chk("ww_stored", 32'(dataOutA), 32'hAAAA);

        drive(1'b1, 8'd20, 16'h1111, 1'b1, 8'd21, 16'h2222);
        run_cycle("ww_diff");
        drive(1'b0, 8'd21, 16'h0, 1'b0, 8'd20, 16'h0);
        run_cycle("ww_diff_rd");
        chk("diff_A", 32'(dataOutA), 32'h2222);
        chk("diff_B", 32'(dataOutB), 32'h1111);

        // Dense random traffic on a small window to force frequent collisions.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 16'($urandom),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 16'($urandom));
            run_cycle("rand");
        end

        drive(1'b1, 8'd5, 16'hBEEF, 1'b0, 8'd5, 16'h0);
        run_cycle("wr_beef");
        drive(1'b0, 8'd5, 16'h0, 1'b0, 8'd5, 16'h0);
        run_cycle("rd_beef");
        chk("beef", 32'(dataOutA), 32'hBEEF);

        pulse_reset("mid_run");
        drive(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 16'h0);
        for (int i = 0; i < 255; i++) run_cycle("init2");
        chk("ready_low_255", 32'(ready), 32'h0);
        run_cycle("init2_last");
        chk("ready_after_256", 32'(ready), 32'h1);

        drive(1'b0, 8'd5, 16'h0, 1'b0, 8'd255, 16'h0);
        run_cycle("rd5_after_reset");
        chk("addr5_reinit", 32'(dataOutA), 32'h0006);
        chk("addr255_reinit", 32'(dataOutB), 32'h0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
